// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp scheduler.
// Holds the channel count, the default frame length, the power-up servo
// position, the scheduler state encoding and the per-frame ramp function
// used by the top level when it updates one channel.
package servo_pkg;

    localparam int         NUM_CH           = 4;
    localparam int         FRAME_CYCLES_DEF = 1000000;
    localparam logic [7:0] POS_CENTER       = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1,
        ST_STB  = 2'd2
    } state_e;

    // Next position after one frame: move toward target by at most step,
    // a zero step means jump straight to target. The 9-bit signed difference
    // keeps the full -255..255 range so the result can never overshoot or wrap.
    function automatic logic [7:0] ramp_next(
        input logic [7:0] pos,
        input logic [7:0] target,
        input logic [3:0] step
    );
        logic signed [8:0] diff;
        logic        [8:0] mag;
        logic        [7:0] step8;
        logic        [7:0] result;
        diff  = $signed({1'b0, target}) - $signed({1'b0, pos});
        step8 = {4'd0, step};
        if (diff[8]) begin
            mag = 9'(-diff);
        end else begin
            mag = 9'(diff);
        end
        if ((step == 4'd0) || (mag <= {1'b0, step8})) begin
            result = target;
        end else if (diff[8]) begin
            result = pos - step8;
        end else begin
            result = pos + step8;
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame timer.
// Counts 0..FRAME_CYCLES-1 and wraps; tick is high for the single cycle in
// which the count sits at its last value, marking the end of a servo frame.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, count returns to 0
//   tick - high while count == FRAME_CYCLES-1
module servo_frame_timer #(
    parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CNT_W   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap to zero after the last cycle of the frame.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Servo ramp scheduler.
// Once per frame it sweeps the channels in order, spending one cycle (UPD)
// moving each enabled channel's position toward its target and one cycle
// (STB) arming that channel's load strobe if the position changed. The new
// position is therefore on rot_out one cycle before set_rot rises.
// Commands are only accepted between sweeps.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   cmd_valid/ready - command handshake, ready only while idle
//   cmd_chan        - channel written by the command
//   cmd_target      - target position 0..255
//   cmd_step        - max change per frame, 0 = jump to target
//   cmd_en          - channel enable
//   rot_out         - per-channel position, channel k on bits [8k+7:8k]
//   set_rot         - one-cycle per-channel load strobe
//   servo_en        - per-channel driver enable
//   at_target       - per-channel position == target
//   frame_start     - one-cycle pulse in the cycle after the frame tick
module servo_ramp_scheduler #(
    parameter int NUM_CH       = servo_pkg::NUM_CH,
    parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(NUM_CH)-1:0] cmd_chan,
    input  logic [7:0]                cmd_target,
    input  logic [3:0]                cmd_step,
    input  logic                      cmd_en,
    output logic [8*NUM_CH-1:0]       rot_out,
    output logic [NUM_CH-1:0]         set_rot,
    output logic [NUM_CH-1:0]         servo_en,
    output logic [NUM_CH-1:0]         at_target,
    output logic                      frame_start
);
    import servo_pkg::*;

    localparam int              CH_W    = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e              state_q,  state_d;
    logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
    logic [7:0]          pos_q    [NUM_CH];
    logic [7:0]          pos_d    [NUM_CH];
    logic [7:0]          target_q [NUM_CH];
    logic [7:0]          target_d [NUM_CH];
    logic [3:0]          step_q   [NUM_CH];
    logic [3:0]          step_d   [NUM_CH];
    logic [NUM_CH-1:0]   en_q,      en_d;
    logic                pend_q,    pend_d;
    logic [NUM_CH-1:0]   set_rot_q, set_rot_d;
    logic                frame_start_q, frame_start_d;

    logic                tick_s;
    logic                cmd_fire_s;
    logic [7:0]          upd_pos_s;

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Command capture, sweep sequencing and per-channel ramp update.
    always_comb begin
        state_d       = state_q;
        ch_idx_d      = ch_idx_q;
        pos_d         = pos_q;
        target_d      = target_q;
        step_d        = step_q;
        en_d          = en_q;
        pend_d        = pend_q;
        set_rot_d     = {NUM_CH{1'b0}};
        frame_start_d = tick_s;
        upd_pos_s     = ramp_next(pos_q[ch_idx_q], target_q[ch_idx_q], step_q[ch_idx_q]);
        cmd_fire_s    = cmd_valid && (state_q == ST_IDLE);

        // A command landing on the tick edge is visible to the sweep that
        // starts right after, since UPD reads the registered settings.
        if (cmd_fire_s) begin
            target_d[cmd_chan] = cmd_target;
            step_d[cmd_chan]   = cmd_step;
            en_d[cmd_chan]     = cmd_en;
        end else begin
            target_d = target_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d  = ST_UPD;
                    ch_idx_d = {CH_W{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_UPD: begin
                // pend remembers whether STB must fire the strobe.
                if (en_q[ch_idx_q] && (upd_pos_s != pos_q[ch_idx_q])) begin
                    pos_d[ch_idx_q] = upd_pos_s;
                    pend_d          = 1'b1;
                end else begin
                    pend_d          = 1'b0;
                end
                state_d = ST_STB;
            end
            ST_STB: begin
                if (pend_q) begin
                    set_rot_d[ch_idx_q] = 1'b1;
                end else begin
                    set_rot_d = {NUM_CH{1'b0}};
                end
                pend_d = 1'b0;
                if (ch_idx_q != LAST_CH) begin
                    state_d  = ST_UPD;
                    ch_idx_d = ch_idx_q + CH_W'(1);
                end else begin
                    state_d  = ST_IDLE;
                    ch_idx_d = {CH_W{1'b0}};
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ch_idx_d = {CH_W{1'b0}};
                pend_d   = 1'b0;
            end
        endcase
    end

    // State, channel settings and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ch_idx_q      <= {CH_W{1'b0}};
            pos_q         <= '{default: POS_CENTER};
            target_q      <= '{default: POS_CENTER};
            step_q        <= '{default: 4'd0};
            en_q          <= {NUM_CH{1'b0}};
            pend_q        <= 1'b0;
            set_rot_q     <= {NUM_CH{1'b0}};
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_idx_q      <= ch_idx_d;
            pos_q         <= pos_d;
            target_q      <= target_d;
            step_q        <= step_d;
            en_q          <= en_d;
            pend_q        <= pend_d;
            set_rot_q     <= set_rot_d;
            frame_start_q <= frame_start_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign rot_out[8*k +: 8] = pos_q[k];
        assign at_target[k]      = (pos_q[k] == target_q[k]);
    end

    assign set_rot     = set_rot_q;
    assign servo_en    = en_q;
    assign frame_start = frame_start_q;
    assign cmd_ready   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Self-checking bench for servo_ramp_scheduler with a short frame.
// The reference model works on a timeline: at each frame tick it computes
// every channel's new position with plain arithmetic, then publishes
// channel k's value 2+2k cycles after the tick and its strobe 3+2k cycles
// after the tick. Commands are accepted whenever the sweep window is closed.
module tb_servo_ramp_scheduler;

    localparam int FC = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_chan;
    logic [7:0]  cmd_target;
    logic [3:0]  cmd_step;
    logic        cmd_en;
    logic [31:0] rot_out;
    logic [3:0]  set_rot;
    logic [3:0]  servo_en;
    logic [3:0]  at_target;
    logic        frame_start;

    always #5 clk = ~clk;

    servo_ramp_scheduler #(
        .NUM_CH       (4),
        .FRAME_CYCLES (FC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_chan    (cmd_chan),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .cmd_en      (cmd_en),
        .rot_out     (rot_out),
        .set_rot     (set_rot),
        .servo_en    (servo_en),
        .at_target   (at_target),
        .frame_start (frame_start)
    );

    int checks = 0;
    int errors = 0;

    // model state
    int   n;          // cycles since reset release
    int   t_tick;     // cycle index of latest frame tick
    int   m_pos[4], m_tgt[4], m_step[4], m_en[4], m_nxt[4];
    bit   m_chg[4];
    logic [31:0] exp_rot;
    logic [3:0]  exp_set, exp_en, exp_at;
    logic        exp_fs, exp_rdy;

    function automatic int ramp(int p, int t, int s);
        int d;
        d = t - p;
        if (s == 0 || (d <= s && d >= -s)) return t;
        return (d > 0) ? p + s : p - s;
    endfunction

    function automatic void compute_exp();
        for (int k = 0; k < 4; k++) begin
            exp_rot[8*k +: 8] = m_pos[k][7:0];
            exp_set[k] = (n == t_tick + 3 + 2*k) && m_chg[k];
            exp_en[k]  = (m_en[k] != 0);
            exp_at[k]  = (m_pos[k] == m_tgt[k]);
        end
        exp_fs  = (n == t_tick + 1);
        exp_rdy = !(n >= t_tick + 1 && n <= t_tick + 8);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_pos[k] = 128; m_tgt[k] = 128; m_step[k] = 0; m_en[k] = 0;
            m_nxt[k] = 128; m_chg[k] = 1'b0;
        end
        n = 0;
        t_tick = -1000;
        compute_exp();
    endfunction

    // Advance one clock; inputs stay as driven, outputs sampled at negedge.
    task automatic clk_step();
        int  c, ch, tg, st, en;
        bit  acc, was_rst;
        c = n; was_rst = rst; acc = cmd_valid && exp_rdy;
        ch = cmd_chan; tg = cmd_target; st = cmd_step; en = cmd_en;
        @(posedge clk);
        if (was_rst) begin
            model_reset();
        end else begin
            if (acc) begin
                m_tgt[ch] = tg; m_step[ch] = st; m_en[ch] = en;
            end
            if (c % FC == FC - 1) begin
                t_tick = c;
                for (int k = 0; k < 4; k++) begin
                    m_nxt[k] = (m_en[k] != 0) ? ramp(m_pos[k], m_tgt[k], m_step[k]) : m_pos[k];
                    m_chg[k] = (m_nxt[k] != m_pos[k]);
                end
            end
            for (int k = 0; k < 4; k++)
                if (c == t_tick + 1 + 2*k) m_pos[k] = m_nxt[k];
            n = c + 1;
            compute_exp();
        end
        @(negedge clk);
    endtask

    task automatic send_cmd(input int ch, input int tg, input int st, input int en);
        int guard = 0;
        cmd_chan = 2'(ch); cmd_target = 8'(tg); cmd_step = 4'(st); cmd_en = en[0];
        cmd_valid = 1'b1;
        while (!exp_rdy && guard < 50) begin clk_step(); guard++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_at_send n=%0d got %b exp 1", n, cmd_ready);
        end
        clk_step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int guard = 0;
        while (!exp_fs && guard < 3*FC) begin clk_step(); guard++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_step(); rst = 1'b0;
        checks += 6;
        if (rot_out !== 32'h80808080) begin errors++; $display("FAIL rst_rot got %h exp 80808080", rot_out); end
        if (set_rot !== 4'h0) begin errors++; $display("FAIL rst_set got %h exp 0", set_rot); end
        if (servo_en !== 4'h0) begin errors++; $display("FAIL rst_en got %h exp 0", servo_en); end
        if (at_target !== 4'hF) begin errors++; $display("FAIL rst_at got %h exp f", at_target); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got %b exp 0", frame_start); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b exp 1", cmd_ready); end
        for (int i = 0; i < 3*FC; i++) begin
            clk_step();
            checks += 4;
            if (rot_out !== 32'h80808080) begin errors++; $display("FAIL idle_rot n=%0d got %h exp 80808080", n, rot_out); end
            if (set_rot !== 4'h0) begin errors++; $display("FAIL idle_set n=%0d got %h exp 0", n, set_rot); end
            if (at_target !== 4'hF) begin errors++; $display("FAIL idle_at n=%0d got %h exp f", n, at_target); end
            if (frame_start !== exp_fs) begin errors++; $display("FAIL idle_fs n=%0d got %b exp %b", n, frame_start, exp_fs); end
        end
    endtask

    task automatic test_ramp();
        int seen[$];
        int expv[3] = '{133, 138, 140};
        int last_fs = -1;
        send_cmd(1, 140, 5, 1);
        for (int i = 0; i < 4*FC; i++) begin
            clk_step();
            if (frame_start) last_fs = n;
            checks += 2;
            if (rot_out !== exp_rot) begin errors++; $display("FAIL ramp_rot n=%0d got %h exp %h", n, rot_out, exp_rot); end
            if (set_rot !== exp_set) begin errors++; $display("FAIL ramp_set n=%0d got %h exp %h", n, set_rot, exp_set); end
            if (set_rot[1]) begin
                seen.push_back(int'(rot_out[15:8]));
                checks++;
                if (n - last_fs != 4) begin errors++; $display("FAIL ramp_strobe_time got %0d exp 4", n - last_fs); end
            end
        end
        checks++;
        if (seen.size() != 3) begin errors++; $display("FAIL ramp_strobe_count got %0d exp 3", seen.size()); end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] != expv[i]) begin errors++; $display("FAIL ramp_pos%0d got %0d exp %0d", i, seen[i], expv[i]); end
        end
        checks++;
        if (at_target[1] !== 1'b1) begin errors++; $display("FAIL ramp_at got %b exp 1", at_target[1]); end
    endtask

    task automatic test_jump_clamp();
        int p0 = 0, p2 = 0;
        send_cmd(2, 0, 0, 1);
        send_cmd(0, 250, 0, 1);
        for (int i = 0; i < 5*FC/2; i++) begin
            clk_step();
            if (set_rot[2]) p2++;
            checks++;
            if (set_rot !== exp_set) begin errors++; $display("FAIL jump_set n=%0d got %h exp %h", n, set_rot, exp_set); end
        end
        checks += 3;
        if (rot_out[23:16] !== 8'd0) begin errors++; $display("FAIL jump_ch2 got %0d exp 0", rot_out[23:16]); end
        if (rot_out[7:0] !== 8'd250) begin errors++; $display("FAIL jump_ch0 got %0d exp 250", rot_out[7:0]); end
        if (p2 != 1) begin errors++; $display("FAIL jump_ch2_pulses got %0d exp 1", p2); end
        send_cmd(0, 255, 15, 1);
        for (int i = 0; i < 5*FC/2; i++) begin
            clk_step();
            if (set_rot[0]) p0++;
            checks++;
            if (rot_out !== exp_rot) begin errors++; $display("FAIL clamp_rot n=%0d got %h exp %h", n, rot_out, exp_rot); end
        end
        checks += 3;
        if (rot_out[7:0] !== 8'd255) begin errors++; $display("FAIL clamp_ch0 got %0d exp 255", rot_out[7:0]); end
        if (p0 != 1) begin errors++; $display("FAIL clamp_pulses got %0d exp 1", p0); end
        if (at_target[0] !== 1'b1) begin errors++; $display("FAIL clamp_at got %b exp 1", at_target[0]); end
    endtask

    task automatic test_stall();
        int p2 = 0;
        wait_fs();
        cmd_chan = 2'd2; cmd_target = 8'd10; cmd_step = 4'd3; cmd_en = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_rdy off=%0d got %b exp 0", i + 1, cmd_ready); end
            clk_step();
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy off=9 got %b exp 1", cmd_ready); end
        clk_step();
        cmd_valid = 1'b0;
        checks++;
        if (servo_en[2] !== 1'b0) begin errors++; $display("FAIL stall_en got %b exp 0", servo_en[2]); end
        for (int g = 0; g < 2*FC && (n % FC) != FC - 1; g++) clk_step();
        cmd_chan = 2'd2; cmd_target = 8'd20; cmd_step = 4'd0; cmd_en = 1'b1; cmd_valid = 1'b1;
        clk_step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clk_step();
            if (set_rot[2]) p2++;
            checks++;
            if (set_rot !== exp_set) begin errors++; $display("FAIL tickcmd_set n=%0d got %h exp %h", n, set_rot, exp_set); end
        end
        checks += 2;
        if (rot_out[23:16] !== 8'd20) begin errors++; $display("FAIL tickcmd_ch2 got %0d exp 20", rot_out[23:16]); end
        if (p2 != 1) begin errors++; $display("FAIL tickcmd_pulses got %0d exp 1", p2); end
    endtask

    task automatic test_disable();
        send_cmd(3, 200, 4, 0);
        for (int i = 0; i < 5*FC/2; i++) begin
            clk_step();
            checks += 2;
            if (set_rot[3] !== 1'b0) begin errors++; $display("FAIL dis_set n=%0d got 1 exp 0", n); end
            if (servo_en[3] !== 1'b0) begin errors++; $display("FAIL dis_en n=%0d got 1 exp 0", n); end
        end
        checks++;
        if (rot_out[31:24] !== 8'd128) begin errors++; $display("FAIL dis_pos got %0d exp 128", rot_out[31:24]); end
        send_cmd(3, 200, 4, 1);
        checks++;
        if (servo_en[3] !== 1'b1) begin errors++; $display("FAIL en_follow got %b exp 1", servo_en[3]); end
        wait_fs();
        for (int i = 0; i < 8; i++) clk_step();
        checks++;
        if (rot_out[31:24] !== 8'd132) begin errors++; $display("FAIL en_resume got %0d exp 132", rot_out[31:24]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            send_cmd($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 15),
                     ($urandom_range(0, 3) != 0) ? 1 : 0);
            for (int i = $urandom_range(0, 120); i > 0; i--) begin
                clk_step();
                checks += 6;
                if (rot_out !== exp_rot) begin errors++; $display("FAIL rnd_rot n=%0d got %h exp %h", n, rot_out, exp_rot); end
                if (set_rot !== exp_set) begin errors++; $display("FAIL rnd_set n=%0d got %h exp %h", n, set_rot, exp_set); end
                if (servo_en !== exp_en) begin errors++; $display("FAIL rnd_en n=%0d got %h exp %h", n, servo_en, exp_en); end
                if (at_target !== exp_at) begin errors++; $display("FAIL rnd_at n=%0d got %h exp %h", n, at_target, exp_at); end
                if (frame_start !== exp_fs) begin errors++; $display("FAIL rnd_fs n=%0d got %b exp %b", n, frame_start, exp_fs); end
                if (cmd_ready !== exp_rdy) begin errors++; $display("FAIL rnd_rdy n=%0d got %b exp %b", n, cmd_ready, exp_rdy); end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt = 0;
        send_cmd(1, 0, 1, 1);
        wait_fs();
        for (int i = 0; i < 3; i++) clk_step();
        rst = 1'b1; clk_step(); rst = 1'b0;
        checks += 6;
        if (rot_out !== 32'h80808080) begin errors++; $display("FAIL mid_rot got %h exp 80808080", rot_out); end
        if (set_rot !== 4'h0) begin errors++; $display("FAIL mid_set got %h exp 0", set_rot); end
        if (servo_en !== 4'h0) begin errors++; $display("FAIL mid_en got %h exp 0", servo_en); end
        if (at_target !== 4'hF) begin errors++; $display("FAIL mid_at got %h exp f", at_target); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs got %b exp 0", frame_start); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b exp 1", cmd_ready); end
        while (!frame_start && cnt < 3*FC) begin
            clk_step(); cnt++;
            checks++;
            if (set_rot !== 4'h0) begin errors++; $display("FAIL mid_quiet n=%0d got %h exp 0", n, set_rot); end
        end
        checks++;
        if (cnt != FC) begin errors++; $display("FAIL mid_restart got %0d exp %0d", cnt, FC); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_chan = 2'd0; cmd_target = 8'd0; cmd_step = 4'd0; cmd_en = 1'b0;
        model_reset();
        test_reset();
        test_ramp();
        test_jump_clamp();
        test_stall();
        test_disable();
        test_random();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_ramp_scheduler.md
SERVO_RAMP_SCHEDULER -- requirements
Module: servo_ramp_scheduler

Interface
REQ-001 Parameter: NUM_CH, 4, number of servo channels served; fixed at 4 in this revision.
REQ-002 Parameter: FRAME_CYCLES, 1000000, clk cycles per servo frame (20 ms at 50 MHz).
REQ-003 Port: clk  input  1  single system clock, 50 MHz, all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid  input  1  command present.
REQ-006 Port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready on a clk edge.
REQ-007 Port: cmd_chan  input  2  target channel index.
REQ-008 Port: cmd_target  input  8  target rotation, 0..255.
REQ-009 Port: cmd_step  input  4  max position change per frame; 0 = jump directly to target.
REQ-010 Port: cmd_en  input  1  channel enable written with the command.
REQ-011 Port: rot_out  output  32  per-channel rotation, channel k on bits [8k+7:8k], feeds servo driver input_rotation.
REQ-012 Port: set_rot  output  4  one-cycle load strobe per channel, feeds servo driver set_rotation.
REQ-013 Port: servo_en  output  4  per-channel driver enable.
REQ-014 Port: at_target  output  4  high when channel position equals its target.
REQ-015 Port: frame_start  output  1  one-cycle pulse on frame tick.

Function
REQ-016 Frame timer counts 0..FRAME_CYCLES-1 and wraps; tick cycle T is the cycle count equals FRAME_CYCLES-1; frame_start is high in cycle T+1.
REQ-017 FSM states IDLE, UPD, STB; IDLE -> UPD (ch_idx=0) on tick; UPD -> STB; STB -> UPD (ch_idx+1) if ch_idx<3, else IDLE.
REQ-018 Sweep timing fixed: each channel takes exactly 2 cycles regardless of enable or at_target; sweep occupies T+1..T+8, IDLE again at T+9.
REQ-019 In UPD for channel k with servo_en[k]=1: pos moves toward target by min(step,|target-pos|); step 0 sets pos=target; pos never overshoots and never wraps past 0 or 255.
REQ-020 New rot_out[k] visible from cycle T+2+2k; set_rot[k] high for exactly cycle T+3+2k, only if pos[k] changed in that UPD; data is stable at least one cycle before strobe rises.
REQ-021 Disabled channel or channel already at target: no position change, no strobe.
REQ-022 cmd_ready = 1 only in IDLE; accepted command writes target, step and enable of cmd_chan in the same edge; commands during a sweep stall until IDLE.
REQ-023 Command accepted on the same edge as tick: new values are used by the sweep starting T+1.
REQ-024 servo_en[k] follows stored enable from the cycle after acceptance; disabling holds pos unchanged.
REQ-025 at_target is combinational compare of stored pos and target, per channel.
REQ-026 Arithmetic: difference computed 9-bit signed; step zero-extended to 8 bits.

Reset
REQ-027 On rst: state IDLE, ch_idx 0, frame count 0, pos and target all 128, step all 0, enables 0.
REQ-028 Outputs in reset: cmd_ready 1 after release, rot_out 0x80808080, set_rot 0, servo_en 0, at_target 0xF, frame_start 0.
REQ-029 rst mid-sweep aborts immediately; no strobe issued in the cycle after rst asserted.

Structure
REQ-030 Package servo_pkg holds NUM_CH, FRAME_CYCLES default, POS_CENTER=128, and FSM state encoding.
REQ-031 Sub-module servo_frame_timer (parameter FRAME_CYCLES, outputs tick) holds the frame counter; scheduler, registers and step logic stay in the top.

Verification (bench uses FRAME_CYCLES=100)
REQ-032 Reset, no commands, run 3 frames -> rot_out 0x80808080, set_rot never high, at_target 0xF.
REQ-033 Cmd ch1 target 140 step 5 en 1 -> pos 133,138,140 over 3 frames, set_rot[1] at T+5 each frame, then no strobes, at_target[1]=1.
REQ-034 Cmd ch2 target 0 step 0 en 1 -> next frame rot_out[23:16]=0, single set_rot[2] pulse; ch0 target 255 step 15 from 250 -> 255, no wrap.
REQ-035 Cmd held valid during sweep -> cmd_ready low T+1..T+8, accepted at T+9; cmd on tick edge -> applied in that sweep.
REQ-036 Ch3 en 0 target 200 -> no position change, no strobe; then en 1 -> ramping resumes next frame.
REQ-037 rst asserted at T+4 -> all state reset values next cycle, set_rot 0, frame counter restarts at 0.
